// File: rtl/sm_be_rx_monitor.sv
// Best-effort packet receive monitor: checks dest/src/seq/length of each packet,
// reports a registered valid/faulty verdict with fault code and keeps saturating counters.
module sm_be_rx_monitor #(
    parameter int FLIT_WIDTH = 32,
    parameter int MAX_LEN    = 8,
    parameter int TILEID     = 0,
    parameter int NUM_TILES  = 9,
    parameter int CHECK_SEQ  = 1,
    parameter int CNT_WIDTH  = 16,
    localparam int H          = FLIT_WIDTH / 2,
    localparam int TILE_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [FLIT_WIDTH-1:0] data,
    input  logic                  clr_cnt,
    output logic                  valid,
    output logic                  faulty,
    output logic [TILE_WIDTH-1:0] src,
    output logic [H-1:0]          seq,
    output logic [3:0]            fault_code,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  cnt_valid,
    output logic [CNT_WIDTH-1:0]  cnt_faulty
);

    localparam logic [H-1:0]         MIN_LEN_H   = H'(3 + CHECK_SEQ);
    localparam logic [H-1:0]         MAX_LEN_H   = H'(MAX_LEN);
    localparam logic [H-1:0]         TILEID_H    = H'(TILEID);
    localparam logic [H-1:0]         NUM_TILES_H = H'(NUM_TILES);
    localparam logic [H-1:0]         ONE_H       = H'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    // fault flag positions inside {LEN,SEQ,SRC,DEST}
    localparam int F_DEST = 0;
    localparam int F_SRC  = 1;
    localparam int F_SEQ  = 2;
    localparam int F_LEN  = 3;

    typedef enum logic [2:0] {
        S_SIZE  = 3'd0,
        S_ROUT  = 3'd1,
        S_DEST  = 3'd2,
        S_SRC   = 3'd3,
        S_SEQ   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                  state_r;
    logic [H-1:0]            rem_r;
    logic [3:0]              flags_r;
    logic [TILE_WIDTH-1:0]   src_r;
    logic [H-1:0]            seq_r;
    logic [H-1:0]            exp_r [NUM_TILES];
    logic [NUM_TILES-1:0]    seen_r;

    logic [H-1:0]            lo_s;
    logic [H-1:0]            hi_s;
    logic                    halves_eq_s;
    logic                    src_known_s;
    state_t                  state_nxt_s;
    logic [3:0]              flags_nxt_s;
    logic [TILE_WIDTH-1:0]   src_nxt_s;
    logic [H-1:0]            seq_nxt_s;
    logic                    last_s;
    logic                    pass_s;
    logic                    tbl_upd_s;

    // Per-flit field checks: flags and latched fields as they stand after this flit.
    always_comb begin
        lo_s        = data[H-1:0];
        hi_s        = data[FLIT_WIDTH-1:H];
        halves_eq_s = (lo_s == hi_s);
        src_known_s = (H'(src_r) < NUM_TILES_H);
        state_nxt_s = state_r;
        flags_nxt_s = flags_r;
        src_nxt_s   = src_r;
        seq_nxt_s   = seq_r;
        case (state_r)
            S_ROUT: begin
                state_nxt_s = S_DEST;
            end
            S_DEST: begin
                if (!halves_eq_s || (lo_s != TILEID_H)) begin
                    flags_nxt_s[F_DEST] = 1'b1;
                end else begin
                    flags_nxt_s[F_DEST] = flags_r[F_DEST];
                end
                state_nxt_s = S_SRC;
            end
            S_SRC: begin
                if (!halves_eq_s || (lo_s >= NUM_TILES_H)) begin
                    flags_nxt_s[F_SRC] = 1'b1;
                end else begin
                    flags_nxt_s[F_SRC] = flags_r[F_SRC];
                end
                src_nxt_s   = data[TILE_WIDTH-1:0];
                state_nxt_s = (CHECK_SEQ != 0) ? S_SEQ : S_DRAIN;
            end
            S_SEQ: begin
                seq_nxt_s = lo_s;
                // a source never seen since reset accepts any sequence number
                if (!halves_eq_s || (src_known_s && seen_r[src_r] && (lo_s != exp_r[src_r]))) begin
                    flags_nxt_s[F_SEQ] = 1'b1;
                end else begin
                    flags_nxt_s[F_SEQ] = flags_r[F_SEQ];
                end
                state_nxt_s = S_DRAIN;
            end
            S_DRAIN: begin
                state_nxt_s = S_DRAIN;
            end
            S_SIZE: begin
                state_nxt_s = S_SIZE;
            end
            default: begin
                state_nxt_s = S_SIZE;
            end
        endcase
        last_s    = enable && (state_r != S_SIZE) && (rem_r == ONE_H);
        pass_s    = (flags_nxt_s == 4'b0000);
        tbl_upd_s = !flags_nxt_s[F_DEST] && !flags_nxt_s[F_SRC] && !flags_nxt_s[F_LEN];
    end

    // Packet FSM, registered verdict outputs and per-source sequence table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_SIZE;
            rem_r      <= '0;
            flags_r    <= 4'b0000;
            src_r      <= '0;
            seq_r      <= '0;
            seen_r     <= '0;
            for (int i = 0; i < NUM_TILES; i++) begin
                exp_r[i] <= '0;
            end
            valid      <= 1'b0;
            faulty     <= 1'b0;
            src        <= '0;
            seq        <= '0;
            fault_code <= 4'b0000;
            busy       <= 1'b0;
        end else begin
            valid  <= 1'b0;
            faulty <= 1'b0;
            if (!enable) begin
                state_r <= state_r;
            end else if (state_r == S_SIZE) begin
                if (lo_s == '0) begin
                    state_r <= S_SIZE;
                end else if ((lo_s < MIN_LEN_H) || (lo_s > MAX_LEN_H)) begin
                    rem_r   <= lo_s;
                    flags_r <= 4'b1000;
                    state_r <= S_DRAIN;
                    busy    <= 1'b1;
                end else begin
                    rem_r   <= lo_s;
                    flags_r <= 4'b0000;
                    state_r <= S_ROUT;
                    busy    <= 1'b1;
                end
            end else if (last_s) begin
                valid      <= pass_s;
                faulty     <= !pass_s;
                src        <= src_nxt_s;
                seq        <= seq_nxt_s;
                fault_code <= flags_nxt_s;
                src_r      <= src_nxt_s;
                seq_r      <= seq_nxt_s;
                flags_r    <= 4'b0000;
                rem_r      <= '0;
                state_r    <= S_SIZE;
                busy       <= 1'b0;
                // resync on a sequence fault too, so one lost packet costs one verdict
                if (tbl_upd_s) begin
                    exp_r[src_nxt_s]  <= seq_nxt_s + ONE_H;
                    seen_r[src_nxt_s] <= 1'b1;
                end else begin
                    seen_r <= seen_r;
                end
            end else begin
                rem_r   <= rem_r - ONE_H;
                state_r <= state_nxt_s;
                flags_r <= flags_nxt_s;
                src_r   <= src_nxt_s;
                seq_r   <= seq_nxt_s;
            end
        end
    end

    // Saturating verdict counters; clear beats a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_valid  <= '0;
            cnt_faulty <= '0;
        end else if (clr_cnt) begin
            cnt_valid  <= '0;
            cnt_faulty <= '0;
        end else begin
            if (last_s && pass_s && (cnt_valid != '1)) begin
                cnt_valid <= cnt_valid + CNT_ONE;
            end else begin
                cnt_valid <= cnt_valid;
            end
            if (last_s && !pass_s && (cnt_faulty != '1)) begin
                cnt_faulty <= cnt_faulty + CNT_ONE;
            end else begin
                cnt_faulty <= cnt_faulty;
            end
        end
    end

endmodule

// File: tb/tb_sm_be_rx_monitor.sv
// Randomised self-checking bench for sm_be_rx_monitor against a packet-level reference model.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_sm_be_rx_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clr_cnt;
    logic [31:0] data;

    logic        valid_a, faulty_a, busy_a;
    logic [3:0]  src_a, fault_code_a;
    logic [15:0] seq_a, cnt_valid_a, cnt_faulty_a;
    logic        valid_b, faulty_b, busy_b;
    logic [3:0]  src_b, fault_code_b;
    logic [15:0] seq_b;
    logic [1:0]  cnt_valid_b, cnt_faulty_b;

    always #5 clk = ~clk;

    sm_be_rx_monitor #(.FLIT_WIDTH(32), .MAX_LEN(8), .TILEID(4), .NUM_TILES(9),
                       .CHECK_SEQ(1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .clr_cnt(clr_cnt),
        .valid(valid_a), .faulty(faulty_a), .src(src_a), .seq(seq_a),
        .fault_code(fault_code_a), .busy(busy_a),
        .cnt_valid(cnt_valid_a), .cnt_faulty(cnt_faulty_a));

    sm_be_rx_monitor #(.FLIT_WIDTH(32), .MAX_LEN(8), .TILEID(4), .NUM_TILES(9),
                       .CHECK_SEQ(1), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .clr_cnt(clr_cnt),
        .valid(valid_b), .faulty(faulty_b), .src(src_b), .seq(seq_b),
        .fault_code(fault_code_b), .busy(busy_b),
        .cnt_valid(cnt_valid_b), .cnt_faulty(cnt_faulty_b));

    // {valid, faulty, fault_code, src, seq, cnt_valid, cnt_faulty}
    wire [57:0] obs_a = {valid_a, faulty_a, fault_code_a, src_a, seq_a, cnt_valid_a, cnt_faulty_a};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_exp [9];
    bit          m_seen [9];
    int          m_cv, m_cf;
    logic [31:0] pkt [$];
    logic [57:0] e_vec, e_mask;
    bit          e_none;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_exp[i]  = 16'd0;
            m_seen[i] = 1'b0;
        end
        m_cv = 0;
        m_cf = 0;
    endtask

    // Packet-level reference: verdict, code, src, seq and counts for the packet in pkt.
    task automatic model_pkt();
        int          size;
        logic [3:0]  code, s4;
        logic [15:0] sq;
        logic [31:0] d, s, q;
        bit          ok;
        size   = int'(pkt[0][15:0]);
        code   = 4'd0;
        s4     = 4'd0;
        sq     = 16'd0;
        e_mask = '1;
        e_none = (size == 0);
        if (size != 0) begin
            if (size < 4 || size > 8) begin
                code = 4'b1000;
                e_mask[51:32] = '0;
            end else begin
                d  = pkt[2];
                s  = pkt[3];
                q  = pkt[4];
                s4 = s[3:0];
                sq = q[15:0];
                if (d[31:16] != d[15:0] || d[15:0] != 16'd4) code[0] = 1'b1;
                if (s[31:16] != s[15:0] || s[15:0] >= 16'd9) code[1] = 1'b1;
                if (q[31:16] != q[15:0]) code[2] = 1'b1;
                else if (s4 < 4'd9 && m_seen[s4] && sq != m_exp[s4]) code[2] = 1'b1;
                if (!code[0] && !code[1]) begin
                    m_exp[s4]  = sq + 16'd1;
                    m_seen[s4] = 1'b1;
                end
            end
            ok = (code == 4'd0);
            if (ok) m_cv++;
            else m_cf++;
            e_vec = {ok, !ok, code, s4, sq, 16'(m_cv), 16'(m_cf)};
        end
    endtask

    task automatic build(input int size, input logic [31:0] dst, input logic [31:0] srcw,
                         input logic [31:0] seqw);
        logic [31:0] body [$];
        pkt.delete();
        pkt.push_back({16'($urandom), 16'(size)});
        body.push_back($urandom);
        body.push_back(dst);
        body.push_back(srcw);
        body.push_back(seqw);
        while (body.size() < size) body.push_back($urandom);
        for (int i = 0; i < size; i++) pkt.push_back(body[i]);
    endtask

    task automatic build_valid(input int k);
        logic [15:0] sq;
        sq = m_seen[k] ? m_exp[k] : 16'($urandom);
        build($urandom_range(8, 4), 32'h00040004, {16'(k), 16'(k)}, {sq, sq});
    endtask

    // Drives pkt with 0..gapmax idle cycles before each flit; the last flit stays on the bus.
    task automatic send(input int gapmax, input bit clr_last);
        for (int i = 0; i < pkt.size(); i++) begin
            repeat ($urandom_range(gapmax, 0)) begin
                @(negedge clk);
                enable  = 1'b0;
                data    = $urandom;
                clr_cnt = 1'b0;
            end
            @(negedge clk);
            enable  = 1'b1;
            data    = pkt[i];
            clr_cnt = clr_last && (i == pkt.size() - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clr_cnt = 1'b0; data = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({obs_a, busy_a} !== 59'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {obs_a, busy_a});
        end
        checks++;
        if ({cnt_valid_b, cnt_faulty_b, valid_b, faulty_b} !== 6'd0) begin
            errors++;
            $display("FAIL reset_cnt_b got %h exp 0", {cnt_valid_b, cnt_faulty_b, valid_b, faulty_b});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        build(5, 32'h00040004, 32'h00020002, 32'h00070007);
        model_pkt();
        send(0, 1'b0);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1", busy_a);
        end
        @(negedge clk); enable = 1'b0;
        checks++;
        if ({valid_a, faulty_a, src_a, seq_a, fault_code_a, cnt_valid_a, busy_a} !==
            {1'b1, 1'b0, 4'd2, 16'd7, 4'd0, 16'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_const got v%b f%b src%0d seq%0d code%b cnt%0d busy%b",
                     valid_a, faulty_a, src_a, seq_a, fault_code_a, cnt_valid_a, busy_a);
        end
        checks++;
        if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
            errors++;
            $display("FAIL basic_model got %h exp %h", obs_a & e_mask, e_vec & e_mask);
        end
        @(negedge clk);
        checks++;
        if ({valid_a, faulty_a, src_a, seq_a} !== {1'b0, 1'b0, 4'd2, 16'd7}) begin
            errors++;
            $display("FAIL basic_pulse_hold got %h exp %h", {valid_a, faulty_a, src_a, seq_a},
                     {1'b0, 1'b0, 4'd2, 16'd7});
        end
        // wrong seq then the resynced one
        for (int j = 0; j < 2; j++) begin
            build(5, 32'h00040004, 32'h00020002, (j == 0) ? 32'h00090009 : 32'h000A000A);
            model_pkt();
            send(0, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if ({valid_a, fault_code_a} !== ((j == 0) ? {1'b0, 4'b0100} : {1'b1, 4'b0000})) begin
                errors++;
                $display("FAIL seq_resync%0d got v%b code%b", j, valid_a, fault_code_a);
            end
            checks++;
            if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
                errors++;
                $display("FAIL seq_model%0d got %h exp %h", j, obs_a & e_mask, e_vec & e_mask);
            end
        end
    endtask

    task automatic test_dest_src();
        logic [3:0] want [3];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            build(6, (j == 0) ? 32'h00040005 : 32'h00040004,
                  (j == 1) ? 32'h00090009 : 32'h00020002, 32'h000B000B);
            model_pkt();
            send(1, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if (fault_code_a !== want[j]) begin
                errors++;
                $display("FAIL dest_src_code%0d got %b exp %b", j, fault_code_a, want[j]);
            end
            checks++;
            if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
                errors++;
                $display("FAIL dest_src_model%0d got %h exp %h", j, obs_a & e_mask, e_vec & e_mask);
            end
        end
    endtask

    task automatic test_len();
        int sizes [7] = '{2, 3, 1, 9, 12, 4, 8};
        for (int j = 0; j < 7; j++) begin
            build(sizes[j], 32'h00040004, 32'h00020002, {m_exp[2], m_exp[2]});
            model_pkt();
            send(1, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if (fault_code_a !== ((sizes[j] < 4 || sizes[j] > 8) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL len_code size%0d got %b", sizes[j], fault_code_a);
            end
            checks++;
            if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
                errors++;
                $display("FAIL len_model size%0d got %h exp %h", sizes[j], obs_a & e_mask, e_vec & e_mask);
            end
        end
        build(32, 32'h00040004, 32'h00020002, {m_exp[2], m_exp[2]});
        model_pkt();
        send(0, 1'b0);
        checks++;
        if ({valid_a, faulty_a, busy_a} !== 3'b001) begin
            errors++;
            $display("FAIL len32_early got %b exp 001", {valid_a, faulty_a, busy_a});
        end
        @(negedge clk); enable = 1'b0;
        checks++;
        if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
            errors++;
            $display("FAIL len32_model got %h exp %h", obs_a & e_mask, e_vec & e_mask);
        end
        pkt.delete();
        pkt.push_back(32'hABCD0000);
        send(0, 1'b0);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_a, faulty_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL len_zero got %b exp 000", {valid_a, faulty_a, busy_a});
        end
    endtask

    task automatic test_gaps();
        for (int j = 0; j < 4; j++) begin
            build(5, 32'h00040004, 32'h00020002, {m_exp[2], m_exp[2]});
            model_pkt();
            send(3, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if ((obs_a & e_mask) !== (e_vec & e_mask) || valid_a !== 1'b1) begin
                errors++;
                $display("FAIL gaps%0d got %h exp %h", j, obs_a & e_mask, e_vec & e_mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] all [$];
        logic [57:0] va, ma;
        int          na;
        build_valid(3);
        model_pkt();
        va = e_vec; ma = e_mask; all = pkt; na = pkt.size();
        build(4, 32'h00070007, 32'h00050005, 32'h00010001);
        model_pkt();
        for (int i = 0; i < pkt.size(); i++) all.push_back(pkt[i]);
        for (int i = 0; i < all.size(); i++) begin
            @(negedge clk);
            if (i == na) begin
                checks++;
                if ((obs_a & ma) !== (va & ma) || valid_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first got %h exp %h", obs_a & ma, va & ma);
                end
            end
            enable = 1'b1;
            data   = all[i];
        end
        @(negedge clk); enable = 1'b0;
        checks++;
        if ((obs_a & e_mask) !== (e_vec & e_mask) || faulty_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", obs_a & e_mask, e_vec & e_mask);
        end
    endtask

    task automatic test_random();
        int          r, k, size;
        logic [15:0] sq;
        logic [31:0] dst, srcw, seqw;
        for (int n = 0; n < 60; n++) begin
            r    = $urandom_range(19, 0);
            k    = $urandom_range(8, 0);
            sq   = (m_seen[k] && $urandom_range(3, 0) != 0) ? m_exp[k] : 16'($urandom);
            size = $urandom_range(8, 4);
            if (r == 0) size = $urandom_range(3, 1);
            else if (r == 1) size = $urandom_range(12, 9);
            else if (r == 2) size = 0;
            dst  = (r == 3) ? 32'h00040006 : (r == 4) ? 32'h00070007 : 32'h00040004;
            srcw = (r == 5) ? 32'h00090009 : (r == 6) ? {16'(k ^ 1), 16'(k)} : {16'(k), 16'(k)};
            seqw = (r == 7) ? {~sq, sq} : {sq, sq};
            build(size, dst, srcw, seqw);
            model_pkt();
            send(2, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if (e_none) begin
                if ({valid_a, faulty_a, busy_a} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand%0d_poll got %b exp 000", n, {valid_a, faulty_a, busy_a});
                end
            end else if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
                errors++;
                $display("FAIL rand%0d got %h exp %h", n, obs_a & e_mask, e_vec & e_mask);
            end
        end
    endtask

    task automatic test_mid_reset();
        build(5, 32'h00040004, 32'h00020002, 32'h00550055);
        @(negedge clk); enable = 1'b1; data = pkt[0];
        @(negedge clk); data = pkt[1];
        @(negedge clk); enable = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy got %b exp 1", busy_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({obs_a, busy_a, cnt_valid_b, cnt_faulty_b} !== 63'd0) begin
            errors++;
            $display("FAIL midrst_clear got %h exp 0", {obs_a, busy_a});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({valid_a, faulty_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_nopulse got %b exp 000", {valid_a, faulty_a, busy_a});
        end
        // exp[2] from before reset must be forgotten
        model_pkt();
        send(0, 1'b0);
        @(negedge clk); enable = 1'b0;
        checks++;
        if ((obs_a & e_mask) !== (e_vec & e_mask) || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_table got %h exp %h", obs_a & e_mask, e_vec & e_mask);
        end
    endtask

    task automatic test_cnt_sat();
        for (int j = 0; j < 4; j++) begin
            build_valid($urandom_range(8, 0));
            model_pkt();
            send(1, 1'b0);
            @(negedge clk); enable = 1'b0;
            checks++;
            if ((obs_a & e_mask) !== (e_vec & e_mask)) begin
                errors++;
                $display("FAIL sat_pkt%0d got %h exp %h", j, obs_a & e_mask, e_vec & e_mask);
            end
        end
        checks++;
        if ({cnt_valid_b, cnt_faulty_b} !== {2'((m_cv > 3) ? 3 : m_cv), 2'((m_cf > 3) ? 3 : m_cf)}) begin
            errors++;
            $display("FAIL sat_cnt_b got %0d/%0d exp valid %0d", cnt_valid_b, cnt_faulty_b, m_cv);
        end
        build_valid(1);
        model_pkt();
        m_cv = 0; m_cf = 0;
        e_vec[31:0] = '0;
        send(0, 1'b1);
        @(negedge clk); enable = 1'b0; clr_cnt = 1'b0;
        checks++;
        if ((obs_a & e_mask) !== (e_vec & e_mask) || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL clr_win_a got %h exp %h", obs_a & e_mask, e_vec & e_mask);
        end
        checks++;
        if ({cnt_valid_b, cnt_faulty_b, valid_b} !== 5'b00001) begin
            errors++;
            $display("FAIL clr_win_b got %b exp 00001", {cnt_valid_b, cnt_faulty_b, valid_b});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dest_src();
        test_len();
        test_gaps();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_cnt_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
